capture_ctrl: RTL and testbench

Capture sequencer for the logic-analyzer digital core. It converts the per-channel CH_H/CH_L sample stream from the analog front end into writes to a circular capture RAM. It qualifies the trigger only after enough pre-trigger history exists, then records a programmed number of post-trigger samples and freezes. One instance controls the shared write port of all channel RAMs. The channel data bits go straight to the RAMs; this block supplies only the write enable and address.

---
 rtl/capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_capture_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl -- capture sequencer for the logic-analyzer digital core.
//
// Turns the decimated sample strobe into write-enable/address for the shared
// circular capture RAM port. After a run it fills pre-trigger history, then
// accepts a trigger, records trig_pos post-trigger samples and freezes with
// waddr pointing at the oldest valid sample.
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous active-high reset
//   smpl_en      valid-sample strobe
//   trig         trigger event (only looked at with smpl_en)
//   run          arm a capture (accepted in IDLE / DONE)
//   abort        cancel any capture
//   clr_done     acknowledge a finished capture
//   trig_pos     post-trigger sample count, latched on an accepted run
//   we           capture RAM write enable (combinational)
//   waddr        capture RAM write address
//   armed        trigger currently accepted
//   triggered    trigger seen, capture post-trigger / done
//   capture_done buffer frozen
//   trig_addr    RAM address of the trigger sample
module capture_ctrl #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              smpl_en,
   input  logic              trig,
   input  logic              run,
   input  logic              abort,
   input  logic              clr_done,
   input  logic [ADDR_W-1:0] trig_pos,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic              armed,
   output logic              triggered,
   output logic              capture_done,
   output logic [ADDR_W-1:0] trig_addr
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_ARMED = 3'd2;
   localparam logic [2:0] S_POST  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ZERO = '0;

   logic [2:0]        state_reg, state_next;
   logic [ADDR_W-1:0] waddr_reg, waddr_next;
   logic [ADDR_W-1:0] taddr_reg, taddr_next;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;
   logic [ADDR_W-1:0] pos_reg, pos_next;

   logic              capturing;
   logic [ADDR_W-1:0] cnt_inc;
   logic [ADDR_W-1:0] waddr_inc;

   assign capturing = (state_reg == S_PRE) || (state_reg == S_ARMED) ||
                      (state_reg == S_POST);
   // abort suppresses the write in its own cycle; rst deliberately does not.
   assign we        = capturing && smpl_en && !abort;
   assign cnt_inc   = cnt_reg + ONE;
   assign waddr_inc = waddr_reg + ONE;

   always_comb begin
      state_next = state_reg;
      waddr_next = waddr_reg;
      taddr_next = taddr_reg;
      cnt_next   = cnt_reg;
      pos_next   = pos_reg;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (run) begin
                  pos_next   = trig_pos;
                  waddr_next = ZERO;
                  taddr_next = ZERO;
                  cnt_next   = ZERO;
                  // Pre-trigger length is DEPTH-1-trig_pos == ~trig_pos.
                  state_next = (~trig_pos == ZERO) ? S_ARMED : S_PRE;
               end else if ((state_reg == S_DONE) && clr_done) begin
                  state_next = S_IDLE;
               end
            end
            S_PRE: begin
               if (we) begin
                  waddr_next = waddr_inc;
                  if (cnt_inc == ~pos_reg) begin
                     cnt_next   = ZERO;
                     state_next = S_ARMED;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
            end
            S_ARMED: begin
               if (we) begin
                  waddr_next = waddr_inc;
                  if (trig) begin
                     taddr_next = waddr_reg;
                     cnt_next   = ZERO;
                     state_next = (pos_reg == ZERO) ? S_DONE : S_POST;
                  end
               end
            end
            S_POST: begin
               if (we) begin
                  waddr_next = waddr_inc;
                  if (cnt_inc == pos_reg) begin
                     cnt_next   = ZERO;
                     state_next = S_DONE;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         waddr_reg <= ZERO;
         taddr_reg <= ZERO;
         cnt_reg   <= ZERO;
         pos_reg   <= ZERO;
      end else begin
         state_reg <= state_next;
         waddr_reg <= waddr_next;
         taddr_reg <= taddr_next;
         cnt_reg   <= cnt_next;
         pos_reg   <= pos_next;
      end
   end

   assign waddr        = waddr_reg;
   assign trig_addr    = taddr_reg;
   assign armed        = (state_reg == S_ARMED);
   assign triggered    = (state_reg == S_POST) || (state_reg == S_DONE);
   assign capture_done = (state_reg == S_DONE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Testbench for capture_ctrl (ADDR_W=4, DEPTH=16). A count-based model tracks
// writes since run and the index of the trigger write; all flags and
// addresses are derived from those counts.
module tb_capture_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst, smpl_en, trig, run, abort, clr_done;
   logic [AW-1:0] trig_pos;
   logic          we, armed, triggered, capture_done;
   logic [AW-1:0] waddr, trig_addr;

   always #5 clk = ~clk;

   capture_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .smpl_en(smpl_en), .trig(trig), .run(run),
      .abort(abort), .clr_done(clr_done), .trig_pos(trig_pos), .we(we),
      .waddr(waddr), .armed(armed), .triggered(triggered),
      .capture_done(capture_done), .trig_addr(trig_addr)
   );

   int tests = 0;
   int fails = 0;
   int we_count = 0;

   // Reference model: a capture is "active" from run until idle again.
   bit m_active   = 1'b0;
   int m_writes   = 0;   // writes since the accepted run
   int m_trig_idx = -1;  // write index of the trigger sample, -1 if none
   int m_pos      = 0;
   int m_waddr    = 0;
   int m_taddr    = 0;

   function automatic bit m_done();
      return m_active && (m_trig_idx >= 0) && (m_writes - m_trig_idx - 1 == m_pos);
   endfunction
   function automatic bit m_armed();
      return m_active && (m_trig_idx < 0) && (m_writes >= DEPTH - 1 - m_pos);
   endfunction
   function automatic bit m_trig();
      return m_active && (m_trig_idx >= 0);
   endfunction
   function automatic bit m_capt();
      return m_active && !m_done();
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check at negedge, update model at posedge.
   task automatic step(input bit rs, input bit s, input bit t, input bit r,
                       input bit a, input bit c);
      bit d, ar, cap;
      rst = rs; smpl_en = s; trig = t; run = r; abort = a; clr_done = c;
      @(negedge clk);
      check("we",           32'(we),           32'(m_capt() && s && !a));
      check("waddr",        32'(waddr),        m_waddr);
      check("trig_addr",    32'(trig_addr),    m_taddr);
      check("armed",        32'(armed),        32'(m_armed()));
      check("triggered",    32'(triggered),    32'(m_trig()));
      check("capture_done", 32'(capture_done), 32'(m_done()));
      if (we === 1'b1) we_count++;
      @(posedge clk);
      d = m_done(); ar = m_armed(); cap = m_capt();
      if (rs) begin
         m_active = 1'b0; m_waddr = 0; m_taddr = 0; m_writes = 0; m_trig_idx = -1;
      end else if (a) begin
         m_active = 1'b0;
      end else if ((!m_active || d) && r) begin
         m_active = 1'b1; m_pos = int'(trig_pos); m_waddr = 0; m_taddr = 0;
         m_writes = 0; m_trig_idx = -1;
      end else if (d && c) begin
         m_active = 1'b0;
      end else if (cap && s) begin
         if (ar && t) begin
            m_trig_idx = m_writes;
            m_taddr    = m_waddr;
         end
         m_writes++;
         m_waddr = (m_waddr + 1) % DEPTH;
      end
      #1;
   endtask

   task automatic go_run(input int tp);
      trig_pos = AW'(tp);
      step(0, 0, 0, 1, 0, 0);
   endtask

   task automatic go_armed(input int budget);
      for (int i = 0; i < budget && !m_armed(); i++) step(0, 1, 0, 0, 0, 0);
      if (!m_armed()) check("armed_timeout", 32'(armed), 32'd1);
   endtask

   task automatic go_done(input int budget);
      for (int i = 0; i < budget && !m_done(); i++) step(0, 1, 1, 0, 0, 0);
      if (!m_done()) check("done_timeout", 32'(capture_done), 32'd1);
   endtask

   initial begin
      bit s, t;
      rst = 1'b1; smpl_en = 1'b0; trig = 1'b0; run = 1'b0; abort = 1'b0;
      clr_done = 1'b0; trig_pos = '0;
      @(posedge clk); #1;
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Normal capture: trig_pos=5, sample every 4th cycle, trig on sample 21.
      we_count = 0;
      go_run(5);
      for (int i = 0; i < 200 && !m_done(); i++) begin
         s = (i % 4 == 3);
         t = s && (m_writes == 20);
         step(0, s, t, 0, 0, 0);
      end
      check("norm_done",   32'(capture_done), 32'd1);
      check("norm_waddr",  32'(waddr),        32'd10);
      check("norm_taddr",  32'(trig_addr),    32'd4);
      check("norm_writes", 32'(we_count),     32'd26);
      step(0, 1, 0, 0, 0, 0);

      // Early triggers on samples 3 and 9 are ignored; sample 15 triggers.
      we_count = 0;
      go_run(5);
      for (int i = 0; i < 200 && !m_done(); i++) begin
         s = (i % 2 == 1);
         t = s && (m_writes == 2 || m_writes == 8 || m_writes == 14);
         step(0, s, t, 0, 0, 0);
      end
      check("early_taddr", 32'(trig_addr), 32'd14);
      check("early_waddr", 32'(waddr),     32'd4);

      // trig_pos = 0: done right after the trigger write.
      we_count = 0;
      go_run(0);
      go_armed(40);
      check("tp0_armed_writes", 32'(we_count), 32'd15);
      step(0, 1, 1, 0, 0, 0);
      check("tp0_done",   32'(capture_done), 32'd1);
      check("tp0_writes", 32'(we_count),     32'd16);
      check("tp0_taddr",  32'(trig_addr),    32'd15);

      // trig_pos = 15: armed right after run, trigger on the first sample.
      go_run(15);
      check("tp15_armed", 32'(armed), 32'd1);
      step(0, 1, 1, 0, 0, 0);
      check("tp15_taddr", 32'(trig_addr), 32'd0);
      check("tp15_trig",  32'(triggered), 32'd1);
      go_done(40);

      // run during ARMED is ignored, abort during POST stops writing.
      go_run(5);
      go_armed(40);
      go_run(3);
      check("run_in_armed", 32'(armed), 32'd1);
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
      check("abort_done", 32'(capture_done), 32'd0);
      check("abort_trig", 32'(triggered),    32'd0);

      // run and abort together -> IDLE.
      go_run(4);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      check("runabort_armed", 32'(armed),     32'd0);
      step(0, 1, 0, 0, 0, 0);

      // run and clr_done together in DONE -> new capture from address 0.
      go_run(2);
      go_armed(40);
      go_done(40);
      trig_pos = AW'(7);
      step(0, 0, 0, 1, 0, 1);
      check("reclr_waddr", 32'(waddr),        32'd0);
      check("reclr_done",  32'(capture_done), 32'd0);
      step(0, 1, 0, 0, 0, 0);

      // Reset held 2 cycles mid-POST.
      go_run(6);
      go_armed(40);
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      check("rst_trig",  32'(triggered), 32'd0);
      check("rst_waddr", 32'(waddr),     32'd0);
      check("rst_taddr", 32'(trig_addr), 32'd0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         trig_pos = AW'($urandom_range(0, DEPTH - 1));
         step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 99) == 0, $urandom_range(0, 14) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
